// File: rtl/fcc_pkg.sv
// -----------------------------------------------------------------------------
// fcc_pkg
// Shared definitions for the FC result write packer: the default geometry of a
// memory write line, the default address width, and the packer FSM states.
// -----------------------------------------------------------------------------
package fcc_pkg;

    // Default memory byte-address width.
    localparam int FCC_ADDR_WIDTH        = 19;
    // Default width of one FC result word (one byte).
    localparam int FCC_WORD_WIDTH        = 8;
    // Default number of result words packed into one memory write line.
    localparam int FCC_NUM_WORDS_IN_LINE = 32;

    // Packer control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for a job start
        ST_FILL = 2'd1,   // collecting result bytes into the line buffer
        ST_REQ  = 2'd2,   // presenting a full or final line to memory
        ST_DONE = 2'd3    // one-cycle job-complete pulse
    } fcc_state_e;

endpackage : fcc_pkg

// File: rtl/fcc_wr_line_buf.sv
// -----------------------------------------------------------------------------
// fcc_wr_line_buf
// One memory write line worth of result words, written one word at a time by
// index and cleared to all-zero in a single cycle so that unused tail words of
// a short final line read back as zero.
//
// Ports
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset, clears the line
//   wr_en    in   write wr_data into word wr_idx
//   wr_idx   in   word index to write
//   wr_data  in   word to write
//   clr      in   clear the whole line (has priority over wr_en)
//   line     out  current line contents, word 0 in the low bits
// -----------------------------------------------------------------------------
module fcc_wr_line_buf
    import fcc_pkg::*;
#(
    parameter  int NUM_WORDS  = FCC_NUM_WORDS_IN_LINE,
    parameter  int WORD_WIDTH = FCC_WORD_WIDTH,
    localparam int IDX_WIDTH  = $clog2(NUM_WORDS)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  wr_en,
    input  logic [IDX_WIDTH-1:0]                  wr_idx,
    input  logic [WORD_WIDTH-1:0]                 wr_data,
    input  logic                                  clr,
    output logic [NUM_WORDS-1:0][WORD_WIDTH-1:0]  line
);

    // NOTE: this storage drives mem_data directly and must read as zero after
    // reset, so it is reset like ordinary state rather than left uninitialised
    // as a RAM would be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line <= '0;
        end else if (clr) begin
            line <= '0;
        end else if (wr_en) begin
            line[wr_idx] <= wr_data;
        end
    end

endmodule : fcc_wr_line_buf

// File: rtl/fcc_wr_packer.sv
// -----------------------------------------------------------------------------
// fcc_wr_packer
// Packs the FC result byte stream into memory write lines. A job starts with a
// one-cycle start pulse that loads the base byte address. Bytes are collected
// until the line is full or the stream's last byte arrives; the line is then
// held on the memory request interface until acknowledged, after which the
// address advances by the line size. After the final line, done pulses once.
//
// Ports
//   clk             in   clock
//   rst_n           in   asynchronous active-low reset, aborts any job
//   start           in   one-cycle job start, honoured only when idle
//   cfg_addrz       in   job base byte address, sampled on start
//   res_valid       in   result byte available
//   res_data        in   result byte
//   res_last        in   this result byte is the final one of the job
//   res_ready       out  a result byte is accepted this cycle when valid
//   mem_req         out  write request, held until mem_ack
//   mem_start_addr  out  line start byte address
//   mem_size_bytes  out  number of valid bytes in the line (1..line size)
//   mem_data        out  line contents, byte 0 in the low bits, unused bytes 0
//   mem_last_valid  out  index of the last valid byte (size - 1)
//   last            out  this line is the final line of the job
//   mem_ack         in   memory accepts the current request
//   busy            out  job in progress
//   done            out  one-cycle job-complete pulse
// -----------------------------------------------------------------------------
module fcc_wr_packer
    import fcc_pkg::*;
#(
    parameter  int ADDR_WIDTH        = FCC_ADDR_WIDTH,
    parameter  int WORD_WIDTH        = FCC_WORD_WIDTH,
    parameter  int NUM_WORDS_IN_LINE = FCC_NUM_WORDS_IN_LINE,
    localparam int CNT_WIDTH         = $clog2(NUM_WORDS_IN_LINE + 1),
    localparam int IDX_WIDTH         = $clog2(NUM_WORDS_IN_LINE)
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  logic [ADDR_WIDTH-1:0]                         cfg_addrz,
    input  logic                                          res_valid,
    input  logic [WORD_WIDTH-1:0]                         res_data,
    input  logic                                          res_last,
    output logic                                          res_ready,
    output logic                                          mem_req,
    output logic [ADDR_WIDTH-1:0]                         mem_start_addr,
    output logic [CNT_WIDTH-1:0]                          mem_size_bytes,
    output logic [NUM_WORDS_IN_LINE-1:0][WORD_WIDTH-1:0]  mem_data,
    output logic [IDX_WIDTH-1:0]                          mem_last_valid,
    output logic                                          last,
    input  logic                                          mem_ack,
    output logic                                          busy,
    output logic                                          done
);

    fcc_state_e              state_q;
    fcc_state_e              state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;     // start address of the line being built
    logic [CNT_WIDTH-1:0]    count_q;    // bytes collected in the current line
    logic                    last_q;     // current line carries the final byte

    logic                    accept;     // a result byte is taken this cycle
    logic                    line_fill;  // this accept completes the line
    logic                    retire;     // the pending line is acknowledged
    logic                    buf_clr;

    assign accept    = (state_q == ST_FILL) && res_valid;
    assign line_fill = accept &&
                       (res_last || (count_q == CNT_WIDTH'(NUM_WORDS_IN_LINE - 1)));
    // Only one acknowledge is honoured per REQ entry: the state leaves REQ on
    // the same edge, so an ack held high afterwards lands in FILL/DONE/IDLE.
    assign retire    = (state_q == ST_REQ) && mem_ack;
    assign buf_clr   = retire || ((state_q == ST_IDLE) && start);

    // ---------------------------------------------------------------- state reg
    // NOTE: every clocked register uses non-blocking assignment so all of them
    // update together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // --------------------------------------------------------------- next state
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start)     state_d = ST_FILL;
            ST_FILL: if (line_fill) state_d = ST_REQ;
            ST_REQ:  if (mem_ack)   state_d = last_q ? ST_DONE : ST_FILL;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- output comb
    always_comb begin
        res_ready      = 1'b0;
        mem_req        = 1'b0;
        mem_size_bytes = '0;
        mem_last_valid = '0;
        last           = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        unique case (state_q)
            ST_IDLE: busy      = 1'b0;
            ST_FILL: res_ready = 1'b1;
            ST_REQ: begin
                mem_req        = 1'b1;
                mem_size_bytes = count_q;
                mem_last_valid = IDX_WIDTH'(count_q - CNT_WIDTH'(1));
                last           = last_q;
            end
            ST_DONE: done      = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    assign mem_start_addr = addr_q;

    // ---------------------------------------------------- address / count / last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q  <= cfg_addrz;
                        count_q <= '0;
                        last_q  <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        count_q <= count_q + CNT_WIDTH'(1);
                        last_q  <= res_last;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        // Address wraps silently at the top of the byte space.
                        addr_q  <= addr_q + ADDR_WIDTH'(count_q);
                        count_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------- line buffer
    fcc_wr_line_buf #(
        .NUM_WORDS  (NUM_WORDS_IN_LINE),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_line_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_idx  (count_q[IDX_WIDTH-1:0]),
        .wr_data (res_data),
        .clr     (buf_clr),
        .line    (mem_data)
    );

endmodule : fcc_wr_packer

// File: tb/tb_fcc_wr_packer.sv
// -----------------------------------------------------------------------------
// tb_fcc_wr_packer
// Self-checking bench for fcc_wr_packer. Each job's expected write lines are
// computed from the byte stream and queued; a responder pops and compares them
// as mem_req appears, then acknowledges with a configurable delay and hold.
// -----------------------------------------------------------------------------
module tb_fcc_wr_packer;

    localparam int AW = 19;
    localparam int NW = 32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [AW-1:0]         cfg_addrz;
    logic                  res_valid;
    logic [7:0]            res_data;
    logic                  res_last;
    logic                  res_ready;
    logic                  mem_req;
    logic [AW-1:0]         mem_start_addr;
    logic [5:0]            mem_size_bytes;
    logic [NW-1:0][7:0]    mem_data;
    logic [4:0]            mem_last_valid;
    logic                  last;
    logic                  mem_ack;
    logic                  busy;
    logic                  done;

    always #5 clk = ~clk;

    fcc_wr_packer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cfg_addrz      (cfg_addrz),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .res_last       (res_last),
        .res_ready      (res_ready),
        .mem_req        (mem_req),
        .mem_start_addr (mem_start_addr),
        .mem_size_bytes (mem_size_bytes),
        .mem_data       (mem_data),
        .mem_last_valid (mem_last_valid),
        .last           (last),
        .mem_ack        (mem_ack),
        .busy           (busy),
        .done           (done)
    );

    typedef struct {
        logic [AW-1:0]  addr;
        logic [5:0]     size;
        logic [255:0]   data;
        logic           lst;
    } line_t;

    line_t exp_q[$];
    int    checks   = 0;
    int    errors   = 0;
    int    done_cnt = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic logic [7:0] pat_byte(input int seed, input int i);
        return 8'((seed + i) & 255);
    endfunction

    // Expected lines for a stream of n bytes starting at base.
    task automatic build_expected(input logic [AW-1:0] base, input int n,
                                  input int seed, input bit has_last);
        logic [AW-1:0] a = base;
        for (int s = 0; s < n; s += NW) begin
            line_t e;
            int    sz = (n - s < NW) ? (n - s) : NW;
            e.addr = a;
            e.size = 6'(sz);
            e.data = '0;
            for (int j = 0; j < sz; j++) e.data[j*8 +: 8] = pat_byte(seed, s + j);
            e.lst  = has_last && (s + sz == n);
            exp_q.push_back(e);
            a = a + AW'(sz);
        end
    endtask

    task automatic send_stream(input int n, input int seed, input bit has_last,
                               input int glitch_at);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            res_valid = 1'b1;
            res_data  = pat_byte(seed, i);
            res_last  = has_last && (i == n - 1);
            if (i == glitch_at) begin
                start     = 1'b1;
                cfg_addrz = 19'h55555;
            end
            @(negedge clk);
            while (!res_ready && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (!res_ready) begin
                check("prod_timeout", res_ready, 1'b1);
                break;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        res_valid = 1'b0;
        res_last  = 1'b0;
    endtask

    task automatic respond(input int n_lines, input int delay, input int hold,
                           input bit abort_last);
        for (int l = 0; l < n_lines; l++) begin
            int    t = 0;
            line_t e;
            @(negedge clk);
            while (!mem_req && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (!mem_req) begin
                check("req_timeout", mem_req, 1'b1);
                return;
            end
            if (exp_q.size() == 0) begin
                check("unexpected_line", 1'b1, 1'b0);
                return;
            end
            e = exp_q.pop_front();
            check("addr",       mem_start_addr, e.addr);
            check("size",       mem_size_bytes, e.size);
            check("last_valid", mem_last_valid, 5'(e.size - 6'd1));
            check("last",       last,           e.lst);
            check("data",       mem_data,       e.data);
            check("ready_req",  res_ready,      1'b0);
            if (abort_last && l == n_lines - 1) return;
            repeat (delay) begin
                @(negedge clk);
                check("hold_req",   mem_req,        1'b1);
                check("hold_ready", res_ready,      1'b0);
                check("hold_addr",  mem_start_addr, e.addr);
                check("hold_size",  mem_size_bytes, e.size);
                check("hold_last",  last,           e.lst);
                check("hold_data",  mem_data,       e.data);
            end
            mem_ack = 1'b1;
            repeat (hold) @(posedge clk);
            #1;
            mem_ack = 1'b0;
        end
    endtask

    task automatic run_job(input logic [AW-1:0] base, input int n, input int seed,
                           input bit has_last, input int delay, input int hold,
                           input int glitch_at, input bit abort_last);
        int d0 = done_cnt;
        build_expected(base, n, seed, has_last);
        start     = 1'b1;
        cfg_addrz = base;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_start", busy, 1'b1);
        fork
            send_stream(n, seed, has_last, glitch_at);
            respond((n + NW - 1) / NW, delay, hold, abort_last);
        join
        if (abort_last) return;
        repeat (6) @(posedge clk);
        #1;
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("busy_idle",   busy,               1'b0);
        check("queue_empty", 32'(exp_q.size()),  32'd0);
    endtask

    initial begin
        int d0;
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_addrz = '0;
        res_valid = 1'b0;
        res_data  = '0;
        res_last  = 1'b0;
        mem_ack   = 1'b0;
        #1;
        check("rst_req",        mem_req,        1'b0);
        check("rst_busy",       busy,           1'b0);
        check("rst_done",       done,           1'b0);
        check("rst_ready",      res_ready,      1'b0);
        check("rst_addr",       mem_start_addr, '0);
        check("rst_size",       mem_size_bytes, '0);
        check("rst_last_valid", mem_last_valid, '0);
        check("rst_last",       last,           1'b0);
        check("rst_data",       mem_data,       '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Four full lines, the last one flagged.
        run_job(19'h00100, 128, 0, 1'b1, 0, 1, -1, 1'b0);
        // Short single line with zero tail; ack held into DONE/IDLE.
        run_job(19'h00000, 10, 8'h40, 1'b1, 0, 3, -1, 1'b0);
        // Delayed ack while the stream keeps res_valid high; 32/32/6 split.
        run_job(19'h03000, 70, 7, 1'b1, 5, 1, -1, 1'b0);
        // Address wrap at the top of the byte space.
        run_job(19'h7FFF0, 64, 8'h80, 1'b1, 0, 1, -1, 1'b0);

        // Stray acks while idle, then a start pulse in the middle of FILL.
        d0 = done_cnt;
        mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_ack = 1'b0;
        check("idle_ack_req",  mem_req, 1'b0);
        check("idle_ack_busy", busy,    1'b0);
        check("idle_ack_done", 32'(done_cnt - d0), 32'd0);
        run_job(19'h01234, 40, 3, 1'b1, 0, 1, 5, 1'b0);

        // Reset while the second line waits for its ack.
        d0 = done_cnt;
        run_job(19'h00200, 64, 9, 1'b0, 0, 1, -1, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_req",   mem_req,   1'b0);
        check("abort_busy",  busy,      1'b0);
        check("abort_ready", res_ready, 1'b0);
        check("abort_data",  mem_data,  '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        // Fresh job after the abort, ending in a one-byte line.
        run_job(19'h00400, 33, 5, 1'b1, 1, 1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fcc_wr_packer

// File: doc/fcc_wr_packer.md
FCC_WR_PACKER -- requirements
Module: fcc_wr_packer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 19, memory byte-address width.
REQ-002 SHALL have parameter WORD_WIDTH, default 8, result byte width.
REQ-003 SHALL have parameter NUM_WORDS_IN_LINE, default 32, bytes per memory write line.
REQ-004 SHALL have ports: clk  in  1  single clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  one-cycle job start pulse (fc_go qualified).
REQ-006 SHALL have port cfg_addrz  in  ADDR_WIDTH  FC result base byte address, sampled on start.
REQ-007 SHALL have ports res_valid  in  1, res_data  in  WORD_WIDTH, res_last  in  1  FC result byte stream, last marks final output neuron.
REQ-008 SHALL have port res_ready  out  1  packer accepts a result byte this cycle.
REQ-009 SHALL have ports mem_req  out  1, mem_start_addr  out  ADDR_WIDTH, mem_size_bytes  out  6  (1..32), mem_data  out  [31:0][7:0], mem_last_valid  out  5, last  out  1  memory write request.
REQ-010 SHALL have port mem_ack  in  1  memory write accept.
REQ-011 SHALL have ports busy  out  1  job in progress; done  out  1  one-cycle job-complete pulse.

Function
REQ-012 SHALL implement FSM IDLE, FILL, REQ, DONE.
REQ-013 IDLE: start -> FILL, load write address from cfg_addrz, clear byte count; start outside IDLE SHALL be ignored.
REQ-014 FILL: res_ready=1; byte accepted on res_valid&&res_ready, written to mem_data[count], count+1.
REQ-015 FILL -> REQ on the accept that makes count 32 or carries res_last, whichever first; same-cycle both -> single line flagged last.
REQ-016 REQ: res_ready=0; mem_req=1; mem_start_addr, mem_data, mem_size_bytes=count, mem_last_valid=count-1, last=final-line flag SHALL stay stable until mem_ack.
REQ-017 mem_req SHALL assert the cycle after the filling accept (latency 1 cycle byte-to-request for final byte).
REQ-018 On mem_ack in REQ: address += count (mod 2^ADDR_WIDTH, wrap silently), count cleared, unused mem_data bytes zeroed; -> DONE if last line, else FILL.
REQ-019 mem_ack outside REQ SHALL be ignored; mem_ack held high multiple cycles SHALL retire at most one line per REQ entry.
REQ-020 DONE: done=1 for exactly one cycle, -> IDLE.
REQ-021 busy SHALL be 1 in FILL, REQ, DONE; 0 in IDLE.
REQ-022 res_valid in IDLE/REQ/DONE SHALL not be consumed (no byte lost, no byte duplicated).
REQ-023 res_last SHALL only be honoured with res_valid; zero-byte jobs are not supported.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, all outputs 0, count 0, address 0, mem_data all 0.
REQ-025 Reset asserted mid-job (any state) SHALL abort the job with no done pulse and mem_req dropped immediately.

Structure
REQ-026 A shared package fcc_pkg SHALL hold the FSM state enum, NUM_WORDS_IN_LINE, WORD_WIDTH and ADDR_WIDTH constants.
REQ-027 One sub-module fcc_wr_line_buf (32-byte line register with indexed write and clear) is natural; FSM and address counter stay in fcc_wr_packer.

Verification
REQ-028 cfg_addrz=0x100, 128 bytes 0..127 back-to-back, last on byte 127, ack 1 cycle after each req -> 4 lines at 0x100,0x120,0x140,0x160, size 32, last_valid 31, last=1 only on 4th, one done pulse.
REQ-029 cfg_addrz=0, 10 bytes with last on 10th -> one line, size 10, last_valid 9, bytes 10..31 zero, last=1, done.
REQ-030 Ack delayed 5 cycles while res_valid held high -> res_ready=0 during REQ, request fields stable, no byte dropped; scoreboard matches stream.
REQ-031 cfg_addrz=0x7FFF0, 64 bytes -> lines at 0x7FFF0 then 0x00010 (wrap).
REQ-032 Reset pulsed while in REQ after 2nd line -> mem_req=0 immediately, busy=0, no done; fresh start afterwards completes normally.
REQ-033 start pulsed during FILL and mem_ack pulsed in IDLE -> both ignored, address and count unchanged.
